stepmotor_phase_seq: RTL and testbench
======================================

// Module: stepmotor_phase_seq
// PURPOSE
// - Downstream consumer of the 6-bit stepper control PIO word.
// - Decodes enable, direction, half/full mode and 3-bit speed from that word.
// - Generates the 4-coil energisation pattern at a programmable step rate,
//   plus a step strobe and a signed position count, for the motor driver pins.
// - Same clock domain as the PIO; no CDC synchroniser is required.
// PARAMETERS
// - BASE_DIV  default 50000  clk cycles per base tick (1 kHz at 50 MHz); legal >= 2
// - POS_W     default 16     width of the position counter
// PORTS
// - clk          in   1      system clock
// - reset_n      in   1      reset, asynchronous, active-low
// - ctrl_in      in   6      control word from the PIO: [0] enable, [1] dir (1 = fwd),
//                            [2] half_step, [5:3] speed
// - coil_out     out  4      coil drive {A, B, A_n, B_n}
// - step_strobe  out  1      1-cycle pulse on each step
// - phase_idx    out  3      current half-step table index
// - position     out  POS_W  signed step count, two's complement
// BEHAVIOUR
// - Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
// - Reset values: ctrl_q, coil_out, step_strobe, phase_idx and position are 0.
//   The prescaler and interval counter are also 0.
// - ctrl_in is registered into ctrl_q every cycle; all decode uses ctrl_q.
// - Outputs coil_out, step_strobe, phase_idx and position are all registered
//   and update on the same edge.
// - Half-step table, idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
// - coil_out <= en_q ? TABLE[idx_next] : 4'b0000.
//   Latency from a ctrl_in change to coil_out is 2 edges.
// - Disabled (en_q = 0):
//   - coils are de-energised;
//   - the prescaler and interval counter are held at 0;
//   - phase_idx and position are retained.
// - Tick: the prescaler counts 0..BASE_DIV-1 while en_q = 1.
//   tick = (presc == BASE_DIV-1); the prescaler then wraps to 0.
// - limit = 8 - speed: speed 0 gives 8 ticks per step, speed 7 gives 1 tick per step.
// - Step event: tick && (int_cnt >= limit-1).
//   On a step event int_cnt <= 0; otherwise int_cnt increments on each tick.
// - A speed change mid-interval uses the new limit from the next tick.
//   If int_cnt already exceeds the new limit, the step fires on that next tick.
// - First step after enable rises: limit*BASE_DIV cycles after en_q = 1.
// - Index update:
//   - half_step = 1: idx +/- 1, mod 8.
//   - full step (two-coil), idx odd: idx +/- 2, mod 8.
//   - full step, idx even: idx +/- 1, to realign to an odd index.
//   - Wrap-around: 7 -> 0 forward, 0 -> 7 reverse.
// - position: +1 on a forward step, -1 on a reverse step; wraps modulo 2^POS_W.
//   step_strobe = 1 for exactly the step-event cycle.
// - dir or mode change: takes effect on the next step only.
//   The in-flight interval is not restarted.
// - Reset mid-step: all state returns to reset values immediately
//   (asynchronous); no partial step is output.
// STRUCTURE
// - Shared package stepmotor_pkg holds:
//   - CTRL_EN, CTRL_DIR, CTRL_HALF, CTRL_SPD_LSB/MSB bit-index constants;
//   - the 8-entry PHASE_TABLE constant;
//   - the coil_t typedef [3:0].
// - Sub-module stepmotor_tick_gen: the BASE_DIV prescaler, with a clear input
//   and a tick output.
// TESTING (BASE_DIV = 4, POS_W = 16)
// - Reset, then ctrl_in = 6'b000_0_1_1 (speed 0, full, fwd, en)
//   -> coil_out 1000 two edges later;
//   -> first step after 32 cycles to idx 1 (coil 1100);
//   -> then steps every 32 cycles, idx 3, 5, 7, 1, and position counts 1, 2, 3...
// - speed 7, half, fwd, run 9 steps -> a step every 4 cycles;
//   idx sequence wraps 7 -> 0 -> 1; position = 9; step_strobe is exactly 1 cycle wide.
// - From position 0, idx 0, half reverse -> idx 7, position = 16'hFFFF.
//   Then switch to full forward -> next step is idx 7 -> 1.
// - Disable mid-interval at idx 3 -> coil_out 0000 after 2 edges;
//   idx 3 and position are retained.
//   Re-enable -> coil_out 0110, and the first step comes a full limit*4 cycles later.
// - speed 0 running with int_cnt = 5, change to speed 5 (limit 3)
//   -> step fires on the next tick, then every 12 cycles.
// - Assert reset_n low during a step cycle -> all outputs 0 asynchronously;
//   no strobe follows.

Source files
------------

// File: rtl/stepmotor_pkg.sv
// Shared definitions for the stepper phase sequencer.
//   - Bit positions of the 6-bit control word fields.
//   - Half-step coil energisation table, index 0..7, coils {A, B, A_n, B_n}.
//   - next_phase(): table index advance for one step in either direction.
package stepmotor_pkg;

  localparam int CTRL_W       = 6;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_DIR     = 1;
  localparam int CTRL_HALF    = 2;
  localparam int CTRL_SPD_LSB = 3;
  localparam int CTRL_SPD_MSB = 5;

  typedef logic [3:0] coil_t;

  localparam coil_t PHASE_TABLE [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  // Half-step mode moves one table entry. Full-step mode drives two coils,
  // which live at odd indices: from an odd index jump two entries, from an
  // even index move one entry to land back on an odd one. The 3-bit
  // arithmetic gives the 7 <-> 0 wrap for free.
  function automatic logic [2:0] next_phase(input logic [2:0] idx,
                                            input logic       fwd,
                                            input logic       half);
    logic [2:0] delta;
    delta = (half || !idx[0]) ? 3'd1 : 3'd2;
    next_phase = fwd ? (idx + delta) : (idx - delta);
  endfunction

endpackage

// File: rtl/stepmotor_tick_gen.sv
// Base-rate prescaler for the stepper sequencer.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   clear    in   hold the prescaler at 0 (no ticks while high)
//   tick     out  one-cycle pulse every BASE_DIV cycles while clear is low
module stepmotor_tick_gen #(
  parameter int BASE_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BASE_DIV - 1);

  logic [CW-1:0] presc;

  assign tick = !clear && (presc == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (clear || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CW'(1);
    end
  end

endmodule

// File: rtl/stepmotor_phase_seq.sv
// Stepper motor phase sequencer, fed by the 6-bit PIO control word.
// ctrl_in is sampled every cycle (no handshake); all decode works on the
// registered copy, so a control change reaches coil_out two edges later.
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   ctrl_in      in   [0] enable, [1] dir (1 = fwd), [2] half_step, [5:3] speed
//   coil_out     out  coil drive {A, B, A_n, B_n}, 0 when disabled
//   step_strobe  out  one-cycle pulse on each step
//   phase_idx    out  current half-step table index
//   position     out  signed step count, two's complement, wraps
module stepmotor_phase_seq
  import stepmotor_pkg::*;
#(
  parameter int BASE_DIV = 50000,
  parameter int POS_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CTRL_W-1:0] ctrl_in,
  output coil_t             coil_out,
  output logic              step_strobe,
  output logic [2:0]        phase_idx,
  output logic [POS_W-1:0]  position
);

  logic [CTRL_W-1:0] ctrl_q;
  logic              en_q;
  logic              dir_q;
  logic              half_q;
  logic [2:0]        speed_q;

  logic              tick;
  logic [2:0]        int_cnt;
  logic              step;
  logic [2:0]        idx_next;
  logic [POS_W-1:0]  pos_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_in;
    end
  end

  assign en_q    = ctrl_q[CTRL_EN];
  assign dir_q   = ctrl_q[CTRL_DIR];
  assign half_q  = ctrl_q[CTRL_HALF];
  assign speed_q = ctrl_q[CTRL_SPD_MSB:CTRL_SPD_LSB];

  stepmotor_tick_gen #(
    .BASE_DIV (BASE_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!en_q),
    .tick    (tick)
  );

  // Ticks per step is 8 - speed, so the last count before a step is
  // 7 - speed. Using >= means a speed-up that leaves int_cnt past the new
  // limit fires on the very next tick instead of running to wrap.
  assign step = tick && (int_cnt >= (3'd7 - speed_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_cnt <= '0;
    end else if (!en_q || step) begin
      int_cnt <= '0;
    end else if (tick) begin
      int_cnt <= int_cnt + 3'd1;
    end
  end

  // dir and mode are only looked at when a step fires, so changing them
  // never restarts the interval in flight.
  always_comb begin
    idx_next = phase_idx;
    pos_next = position;
    if (step) begin
      idx_next = next_phase(phase_idx, dir_q, half_q);
      pos_next = dir_q ? (position + POS_W'(1)) : (position - POS_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coil_out    <= '0;
      step_strobe <= 1'b0;
      phase_idx   <= '0;
      position    <= '0;
    end else begin
      coil_out    <= en_q ? PHASE_TABLE[idx_next] : 4'b0000;
      step_strobe <= step;
      phase_idx   <= idx_next;
      position    <= pos_next;
    end
  end

endmodule

// File: tb/tb_stepmotor_phase_seq.sv
// Directed testbench for stepmotor_phase_seq with BASE_DIV = 4, POS_W = 16.
module tb_stepmotor_phase_seq;

  localparam int BASE_DIV = 4;
  localparam int POS_W    = 16;

  logic             clk;
  logic             reset_n;
  logic [5:0]       ctrl_in;
  logic [3:0]       coil_out;
  logic             step_strobe;
  logic [2:0]       phase_idx;
  logic [POS_W-1:0] position;

  int n_checks;
  int n_fail;

  stepmotor_phase_seq #(
    .BASE_DIV (BASE_DIV),
    .POS_W    (POS_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ctrl_in     (ctrl_in),
    .coil_out    (coil_out),
    .step_strobe (step_strobe),
    .phase_idx   (phase_idx),
    .position    (position)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    ctrl_in = 6'b0;
    reset_n = 1'b0;
    #1;
    tick_n(2);
    reset_n = 1'b1;
  endtask

  // Counts edges until step_strobe is seen; returns max_cyc on timeout.
  task automatic wait_strobe(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!step_strobe && cyc < max_cyc);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ctrl_in = 6'b0;
    #1;
    n_checks++;
    if ({coil_out, step_strobe, phase_idx, position} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: coil=%b strobe=%b idx=%0d pos=%0d required all 0",
               coil_out, step_strobe, phase_idx, position);
    end
    tick_n(2);
    reset_n = 1'b1;
  endtask

  task automatic test_full_fwd();
    int cyc;
    logic [2:0] exp_idx;
    ctrl_in = 6'b000_0_1_1;
    tick_n(1);
    n_checks++;
    if (coil_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL full_coil_edge1: got %b required 0000", coil_out);
    end
    tick_n(1);
    n_checks++;
    if (coil_out !== 4'b1000) begin
      n_fail++;
      $display("FAIL full_coil_edge2: got %b required 1000", coil_out);
    end
    exp_idx = 3'd1;
    for (int i = 1; i <= 5; i++) begin
      wait_strobe(100, cyc);
      n_checks++;
      if (cyc !== ((i == 1) ? 31 : 32)) begin
        n_fail++;
        $display("FAIL full_interval[%0d]: got %0d cycles required %0d", i, cyc, (i == 1) ? 31 : 32);
      end
      n_checks++;
      if (phase_idx !== exp_idx || position !== POS_W'(i)) begin
        n_fail++;
        $display("FAIL full_step[%0d]: idx=%0d pos=%0d required idx=%0d pos=%0d",
                 i, phase_idx, position, exp_idx, i);
      end
      exp_idx = exp_idx + 3'd2;
    end
    n_checks++;
    if (coil_out !== 4'b1100) begin
      n_fail++;
      $display("FAIL full_coil_idx1: got %b required 1100", coil_out);
    end
  endtask

  task automatic test_half_fast();
    int cyc;
    apply_reset();
    ctrl_in = 6'b111_1_1_1;
    for (int i = 1; i <= 9; i++) begin
      wait_strobe(20, cyc);
      n_checks++;
      if (cyc !== ((i == 1) ? 5 : 3)) begin
        n_fail++;
        $display("FAIL half_interval[%0d]: got %0d cycles required %0d", i, cyc, (i == 1) ? 5 : 3);
      end
      n_checks++;
      if (phase_idx !== 3'(i % 8) || position !== POS_W'(i)) begin
        n_fail++;
        $display("FAIL half_step[%0d]: idx=%0d pos=%0d required idx=%0d pos=%0d",
                 i, phase_idx, position, i % 8, i);
      end
      tick_n(1);
      n_checks++;
      if (step_strobe !== 1'b0) begin
        n_fail++;
        $display("FAIL half_strobe_width[%0d]: got %b required 0", i, step_strobe);
      end
    end
  endtask

  task automatic test_reverse_then_full();
    int cyc;
    apply_reset();
    ctrl_in = 6'b111_1_0_1;
    wait_strobe(20, cyc);
    n_checks++;
    if (cyc !== 5 || phase_idx !== 3'd7 || position !== 16'hFFFF || coil_out !== 4'b1001) begin
      n_fail++;
      $display("FAIL rev_wrap: cyc=%0d idx=%0d pos=%h coil=%b required cyc=5 idx=7 pos=ffff coil=1001",
               cyc, phase_idx, position, coil_out);
    end
    ctrl_in = 6'b111_0_1_1;
    wait_strobe(20, cyc);
    n_checks++;
    if (cyc !== 4 || phase_idx !== 3'd1 || position !== 16'h0000 || coil_out !== 4'b1100) begin
      n_fail++;
      $display("FAIL full_from_7: cyc=%0d idx=%0d pos=%h coil=%b required cyc=4 idx=1 pos=0000 coil=1100",
               cyc, phase_idx, position, coil_out);
    end
  endtask

  task automatic test_disable();
    int cyc;
    apply_reset();
    ctrl_in = 6'b111_1_1_1;
    for (int i = 0; i < 3; i++) wait_strobe(20, cyc);
    ctrl_in = 6'b000_1_1_1;
    tick_n(10);
    ctrl_in = 6'b000_1_1_0;
    tick_n(1);
    n_checks++;
    if (coil_out !== 4'b0110) begin
      n_fail++;
      $display("FAIL dis_coil_edge1: got %b required 0110", coil_out);
    end
    tick_n(1);
    n_checks++;
    if (coil_out !== 4'b0000 || phase_idx !== 3'd3 || position !== 16'd3) begin
      n_fail++;
      $display("FAIL dis_edge2: coil=%b idx=%0d pos=%0d required coil=0000 idx=3 pos=3",
               coil_out, phase_idx, position);
    end
    tick_n(20);
    n_checks++;
    if (coil_out !== 4'b0000 || phase_idx !== 3'd3 || position !== 16'd3) begin
      n_fail++;
      $display("FAIL dis_hold: coil=%b idx=%0d pos=%0d required coil=0000 idx=3 pos=3",
               coil_out, phase_idx, position);
    end
    ctrl_in = 6'b000_1_1_1;
    tick_n(2);
    n_checks++;
    if (coil_out !== 4'b0110) begin
      n_fail++;
      $display("FAIL reen_coil: got %b required 0110", coil_out);
    end
    wait_strobe(100, cyc);
    n_checks++;
    if (cyc !== 31 || phase_idx !== 3'd4 || position !== 16'd4 || coil_out !== 4'b0010) begin
      n_fail++;
      $display("FAIL reen_first_step: cyc=%0d idx=%0d pos=%0d coil=%b required cyc=31 idx=4 pos=4 coil=0010",
               cyc, phase_idx, position, coil_out);
    end
  endtask

  task automatic test_speed_change();
    int cyc;
    apply_reset();
    ctrl_in = 6'b000_1_1_1;
    tick_n(22);
    n_checks++;
    if (phase_idx !== 3'd0 || position !== 16'd0) begin
      n_fail++;
      $display("FAIL spd_pre: idx=%0d pos=%0d required idx=0 pos=0", phase_idx, position);
    end
    ctrl_in = 6'b101_1_1_1;
    wait_strobe(40, cyc);
    n_checks++;
    if (cyc !== 3 || phase_idx !== 3'd1 || position !== 16'd1) begin
      n_fail++;
      $display("FAIL spd_next_tick: cyc=%0d idx=%0d pos=%0d required cyc=3 idx=1 pos=1",
               cyc, phase_idx, position);
    end
    for (int i = 2; i <= 3; i++) begin
      wait_strobe(40, cyc);
      n_checks++;
      if (cyc !== 12 || phase_idx !== 3'(i)) begin
        n_fail++;
        $display("FAIL spd_interval[%0d]: cyc=%0d idx=%0d required cyc=12 idx=%0d", i, cyc, phase_idx, i);
      end
    end
  endtask

  task automatic test_reset_mid_step();
    int cyc;
    int strobes;
    ctrl_in = 6'b111_1_1_1;
    wait_strobe(40, cyc);
    n_checks++;
    if (step_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_setup: strobe=%b required 1", step_strobe);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({coil_out, step_strobe, phase_idx, position} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: coil=%b strobe=%b idx=%0d pos=%0d required all 0",
               coil_out, step_strobe, phase_idx, position);
    end
    tick_n(3);
    reset_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick_n(1);
      if (step_strobe) strobes++;
    end
    n_checks++;
    if (strobes !== 0 || coil_out !== 4'b1000 || phase_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid_after: strobes=%0d coil=%b idx=%0d required strobes=0 coil=1000 idx=0",
               strobes, coil_out, phase_idx);
    end
    wait_strobe(10, cyc);
    n_checks++;
    if (cyc !== 1 || phase_idx !== 3'd1 || position !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_mid_restart: cyc=%0d idx=%0d pos=%0d required cyc=1 idx=1 pos=1",
               cyc, phase_idx, position);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    ctrl_in  = 6'b0;
    test_reset();
    test_full_fwd();
    test_half_fast();
    test_reverse_then_full();
    test_disable();
    test_speed_change();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
